// File: rtl/viterbi_pkg.sv
// Shared types and constants for the 4-state, K=3, 7/5 Viterbi decoder.
package viterbi_pkg;

   localparam int unsigned MW_DEF = 4;
   localparam logic [MW_DEF-1:0] INF = '1;

   localparam logic [1:0] S00 = 2'd0;
   localparam logic [1:0] S01 = 2'd1;
   localparam logic [1:0] S10 = 2'd2;
   localparam logic [1:0] S11 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_OUT  = 2'd2
   } acs_state_e;

   // Expected {c0,c1} on the branch from predecessor {ns[0],x} into ns.
   function automatic logic [1:0] exp_sym(input logic [1:0] ns, input logic x);
      return {ns[1] ^ ns[0] ^ x, ns[1] ^ x};
   endfunction

endpackage

// File: rtl/acs_unit_if.sv
// Symbol, path-metric and decision signals between the ACS stage and its neighbours.
interface acs_unit_if #(
   parameter int unsigned MW = viterbi_pkg::MW_DEF
);
   logic          sym_valid;
   logic [1:0]    sym;
   logic          sym_ready;
   logic [MW-1:0] pm00, pm01, pm10, pm11;
   logic          pm_we;
   logic [MW-1:0] new00, new01, new10, new11;
   logic          dec_valid;
   logic [3:0]    dec;
   logic          dec_ready;
   logic [1:0]    best_state;

   modport master (
      output sym_valid, sym, pm00, pm01, pm10, pm11, dec_ready,
      input  sym_ready, pm_we, new00, new01, new10, new11, dec_valid, dec, best_state
   );

   modport slave (
      input  sym_valid, sym, pm00, pm01, pm10, pm11, dec_ready,
      output sym_ready, pm_we, new00, new01, new10, new11, dec_valid, dec, best_state
   );
endinterface

// File: rtl/acs_butterfly_cell.sv
// Branch metric, saturating add and select for a single next-state.
module acs_butterfly_cell
   import viterbi_pkg::*;
#(
   parameter int unsigned MW = MW_DEF,
   parameter logic [1:0]  NS = S00
) (
   input  logic [1:0]    sym,
   input  logic [MW-1:0] pm0,
   input  logic [MW-1:0] pm1,
   output logic [MW-1:0] pm_sel_c,
   output logic          dec_c
);
   localparam int unsigned WW = MW + 1;
   localparam logic [WW-1:0] INF_W = WW'({MW{1'b1}});

   logic [1:0]    d0, d1;
   logic [1:0]    bm0, bm1;
   logic [WW-1:0] sum0, sum1;
   logic [MW-1:0] cand0, cand1;

   // Hamming distance, widened add clipped at INF, smaller candidate wins (tie -> x=0).
   always_comb begin
      d0    = sym ^ exp_sym(NS, 1'b0);
      d1    = sym ^ exp_sym(NS, 1'b1);
      bm0   = 2'(d0[1]) + 2'(d0[0]);
      bm1   = 2'(d1[1]) + 2'(d1[0]);
      sum0  = {1'b0, pm0} + WW'(bm0);
      sum1  = {1'b0, pm1} + WW'(bm1);
      cand0 = (sum0 >= INF_W) ? {MW{1'b1}} : sum0[MW-1:0];
      cand1 = (sum1 >= INF_W) ? {MW{1'b1}} : sum1[MW-1:0];
      pm_sel_c = cand0;
      dec_c    = 1'b0;
      if (cand1 < cand0) begin
         pm_sel_c = cand1;
         dec_c    = 1'b1;
      end
   end
endmodule

// File: rtl/acs_unit.sv
// ACS stage: four butterfly cells, normalization, best-state search and handshake FSM.
module acs_unit
   import viterbi_pkg::*;
#(
   parameter int unsigned MW      = MW_DEF,
   parameter bit          NORM_EN = 1'b1
) (
   input  logic      clk,
   input  logic      rst_n,
   acs_unit_if.slave bus
);
   localparam logic [MW-1:0] INF_V = {MW{1'b1}};

   acs_state_e    state_q, state_d;
   logic [1:0]    sym_q;
   logic [MW-1:0] pm_c  [4];
   logic [MW-1:0] sel_c [4];
   logic [MW-1:0] fin_c [4];
   logic [MW-1:0] new_q [4];
   logic [3:0]    dec_c, dec_q;
   logic [MW-1:0] min_c, bmin_c;
   logic [1:0]    best_c, best_q;

   assign pm_c[0] = bus.pm00;
   assign pm_c[1] = bus.pm01;
   assign pm_c[2] = bus.pm10;
   assign pm_c[3] = bus.pm11;

   // Predecessors of ns are states 2*ns[0] and 2*ns[0]+1.
   for (genvar ns = 0; ns < 4; ns++) begin : g_cell
      acs_butterfly_cell #(
         .MW (MW),
         .NS (2'(ns))
      ) u_cell (
         .sym      (sym_q),
         .pm0      (pm_c[2*(ns%2)]),
         .pm1      (pm_c[2*(ns%2)+1]),
         .pm_sel_c (sel_c[ns]),
         .dec_c    (dec_c[ns])
      );
   end

   // Normalize non-INF metrics by the minimum, then find the lowest-index minimum.
   always_comb begin
      min_c = sel_c[0];
      for (int i = 1; i < 4; i++) begin
         if (sel_c[i] < min_c) min_c = sel_c[i];
      end
      for (int i = 0; i < 4; i++) begin
         fin_c[i] = sel_c[i];
         if (NORM_EN && (sel_c[i] != INF_V)) fin_c[i] = sel_c[i] - min_c;
      end
      best_c = 2'd0;
      bmin_c = fin_c[0];
      for (int i = 1; i < 4; i++) begin
         if (fin_c[i] < bmin_c) begin
            bmin_c = fin_c[i];
            best_c = 2'(i);
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.sym_valid) state_d = ST_CALC;
         ST_CALC: state_d = ST_OUT;
         ST_OUT:  if (bus.dec_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs; pm_we follows dec_ready so the store write lands with the decision.
   always_comb begin
      bus.sym_ready = 1'b0;
      bus.dec_valid = 1'b0;
      bus.pm_we     = 1'b0;
      case (state_q)
         ST_IDLE: bus.sym_ready = 1'b1;
         ST_OUT: begin
            bus.dec_valid = 1'b1;
            bus.pm_we     = bus.dec_ready;
         end
         default: ;
      endcase
   end

   // Latch the symbol on accept and the ACS results in CALC; hold them otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sym_q  <= 2'd0;
         dec_q  <= 4'd0;
         best_q <= 2'd0;
         for (int i = 0; i < 4; i++) new_q[i] <= '0;
      end else begin
         if ((state_q == ST_IDLE) && bus.sym_valid) sym_q <= bus.sym;
         if (state_q == ST_CALC) begin
            dec_q  <= dec_c;
            best_q <= best_c;
            for (int i = 0; i < 4; i++) new_q[i] <= fin_c[i];
         end
      end
   end

   assign bus.new00      = new_q[0];
   assign bus.new01      = new_q[1];
   assign bus.new10      = new_q[2];
   assign bus.new11      = new_q[3];
   assign bus.dec        = dec_q;
   assign bus.best_state = best_q;
endmodule

// File: tb/tb_acs_unit.sv
// Directed bench for acs_unit with hand-computed expected metrics and decisions.
module tb_acs_unit;
   logic clk = 1'b0;
   logic rst_n;
   int   total  = 0;
   int   bad    = 0;
   int   we_cnt = 0;

   always #5 clk = ~clk;

   acs_unit_if #(.MW(4)) bus ();

   acs_unit #(.MW(4), .NORM_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Count store writes seen at the clock edge.
   always @(posedge clk) if (bus.pm_we) we_cnt <= we_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] new_all();
      return {bus.new00, bus.new01, bus.new10, bus.new11};
   endfunction

   task automatic set_pm(input logic [15:0] pm);
      bus.pm00 = pm[15:12];
      bus.pm01 = pm[11:8];
      bus.pm10 = pm[7:4];
      bus.pm11 = pm[3:0];
   endtask

   // Wait (bounded) for sym_ready, then present one symbol with the given pm and dec_ready.
   task automatic accept(input string tag, input logic [15:0] pm, input logic [1:0] s,
                         input logic dr);
      int n = 0;
      while (!bus.sym_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready"}, 32'(bus.sym_ready), 1);
      set_pm(pm);
      bus.sym       = s;
      bus.sym_valid = 1'b1;
      bus.dec_ready = dr;
      @(negedge clk);
      bus.sym_valid = 1'b0;
      bus.sym       = ~s;
   endtask

   // Full transaction with dec_ready held high.
   task automatic run_vec(input string tag, input logic [15:0] pm, input logic [1:0] s,
                          input logic [15:0] enew, input logic [3:0] edec, input logic [1:0] ebest);
      accept(tag, pm, s, 1'b1);
      chk({tag, "_calc_rdy"}, 32'(bus.sym_ready), 0);
      chk({tag, "_calc_we"}, 32'(bus.pm_we), 0);
      @(negedge clk);
      set_pm(16'h0000);
      chk({tag, "_we"}, 32'(bus.pm_we), 1);
      chk({tag, "_dv"}, 32'(bus.dec_valid), 1);
      chk({tag, "_new"}, 32'(new_all()), 32'(enew));
      chk({tag, "_dec"}, 32'(bus.dec), 32'(edec));
      chk({tag, "_best"}, 32'(bus.best_state), 32'(ebest));
      @(negedge clk);
      chk({tag, "_idle_we"}, 32'(bus.pm_we), 0);
      chk({tag, "_idle_dv"}, 32'(bus.dec_valid), 0);
      chk({tag, "_idle_rdy"}, 32'(bus.sym_ready), 1);
   endtask

   initial begin
      int w0;
      rst_n         = 1'b0;
      bus.sym_valid = 1'b0;
      bus.sym       = 2'b00;
      bus.dec_ready = 1'b1;
      set_pm(16'h0000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst_rdy", 32'(bus.sym_ready), 1);
      chk("rst_we", 32'(bus.pm_we), 0);
      chk("rst_dv", 32'(bus.dec_valid), 0);
      chk("rst_dec", 32'(bus.dec), 0);
      chk("rst_new", 32'(new_all()), 0);
      chk("rst_best", 32'(bus.best_state), 0);

      //       tag     pm{00,01,10,11} sym    new{00,01,10,11} dec      best
      run_vec("s00",  16'h0FFF, 2'b00, 16'h0F2F, 4'b0000, 2'd0);
      run_vec("s11",  16'h0FFF, 2'b11, 16'h2F0F, 4'b0000, 2'd2);
      run_vec("norm", 16'h9ACF, 2'b01, 16'h0402, 4'b0000, 2'd0);
      run_vec("mix",  16'h8215, 2'b10, 16'h2022, 4'b0101, 2'd1);
      run_vec("sat",  16'hEFFF, 2'b11, 16'hFF0F, 4'b0000, 2'd2);
      run_vec("tie",  16'h33FF, 2'b01, 16'h0F0F, 4'b0000, 2'd0);
      run_vec("inf",  16'hFFFF, 2'b10, 16'hFFFF, 4'b0000, 2'd0);

      // Backpressure: decision held, no store write, stray symbol ignored.
      w0 = we_cnt;
      accept("bp", 16'h8215, 2'b10, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_dv", 32'(bus.dec_valid), 1);
         chk("bp_we", 32'(bus.pm_we), 0);
         chk("bp_rdy", 32'(bus.sym_ready), 0);
         chk("bp_new", 32'(new_all()), 32'h2022);
         chk("bp_dec", 32'(bus.dec), 32'h5);
         bus.sym_valid = (i == 2);
         bus.sym       = 2'b11;
         set_pm(16'h0FFF);
         @(negedge clk);
      end
      bus.sym_valid = 1'b0;
      chk("bp_nowrite", 32'(we_cnt), 32'(w0));
      bus.dec_ready = 1'b1;
      #1;
      chk("bp_rel_we", 32'(bus.pm_we), 1);
      @(negedge clk);
      chk("bp_one_pulse", 32'(we_cnt), 32'(w0 + 1));
      chk("bp_idle_we", 32'(bus.pm_we), 0);
      chk("bp_idle_rdy", 32'(bus.sym_ready), 1);
      chk("bp_idle_dv", 32'(bus.dec_valid), 0);
      chk("bp_hold_new", 32'(new_all()), 32'h2022);
      chk("bp_hold_best", 32'(bus.best_state), 1);

      // Reset while in CALC drops the symbol without a store write.
      w0 = we_cnt;
      accept("rm", 16'h9ACF, 2'b01, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rm_dv", 32'(bus.dec_valid), 0);
      chk("rm_we", 32'(bus.pm_we), 0);
      chk("rm_rdy", 32'(bus.sym_ready), 1);
      chk("rm_new", 32'(new_all()), 0);
      chk("rm_dec", 32'(bus.dec), 0);
      chk("rm_best", 32'(bus.best_state), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rm_nowrite", 32'(we_cnt), 32'(w0));
      chk("rm_idle_dv", 32'(bus.dec_valid), 0);

      // Normal operation resumes after the mid-op reset.
      run_vec("post", 16'h0FFF, 2'b00, 16'h0F2F, 4'b0000, 2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/acs_unit.md
Name: acs_unit

Overview:
- Add-Compare-Select stage of the 4-state Viterbi decoder: rate 1/2, K=3, generators 7/5 octal.
- Takes one received 2-bit hard-decision symbol per handshake and reads the current path costs held in the path metric store.
- Computes Hamming branch metrics, then does saturating add / compare / select for all 4 states, with optional normalization.
- Writes the new costs back through a one-cycle write strobe and hands survivor decision bits to the traceback stage with valid/ready.

Parameters:
- MW, 4, path metric width; all-ones (2^MW-1) is INF / saturation value.
- NORM_EN, 1, 1: subtract the minimum new metric from all non-saturated new metrics.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- sym_valid  in  1  received symbol valid.
- sym  in  2  received symbol {c0,c1}, c0 in bit 1.
- sym_ready  out  1  ACS can accept a symbol.
- pm00..pm11  in  MW each  current path costs from the path metric store (4 ports).
- pm_we  out  1  write strobe to the path metric store, one cycle.
- new00..new11  out  MW each  new path costs; valid while pm_we=1 (4 ports).
- dec_valid  out  1  decision word valid.
- dec  out  4  survivor bits; bit i belongs to next-state i.
- dec_ready  in  1  traceback accepts the decision word.
- best_state  out  2  index of the minimum new metric, qualified by dec_valid.

Behaviour:
- Trellis: state s = {b[n-1], b[n-2]}; input b gives next state {b, s[1]}. Outputs c0 = b^s1^s0, c1 = b^s0.
- Predecessors of ns are {ns[0],x} for x in {0,1}, with input b = ns[1].
- Expected symbol from predecessor x: c0 = ns1^ns0^x, c1 = ns1^x. Branch metric = Hamming distance to sym, range 0..2.
- Add: pm_pred + bm, computed at MW+1 bits, saturating at INF.
- Select: the smaller candidate wins; a tie selects x=0. dec[ns] = chosen x.
- Normalize (NORM_EN=1): m = min of the 4 selected values. Every value < INF has m subtracted; INF stays INF. NORM_EN=0: no change.
- best_state: index of the minimum of the final values; ties go to the lowest index.
- FSM states: IDLE, CALC, OUT.
  - IDLE: sym_ready=1. When sym_valid=1, latch sym and go to CALC.
  - CALC: sym_ready=0. Compute from the pm inputs sampled this cycle, register new*/dec/best_state, go to OUT.
  - OUT: dec_valid=1 and outputs are held stable. When dec_ready=1: pm_we=1 for exactly that cycle, then go to IDLE.
- Throughput: max one symbol per 3 cycles. Latency: sym accept to pm_we ≥ 2 cycles (exactly 2 if dec_ready is held high).
- Backpressure: while dec_ready=0 in OUT, pm_we stays 0, so the store is never written before the decision is consumed.
- sym_ready=0 outside IDLE; a sym_valid arriving then is not accepted.
- Reset: rst_n=0 at any edge forces IDLE next cycle; an in-flight symbol is dropped with no pm_we.
- Reset values: sym_ready=1 after reset release, pm_we=0, dec_valid=0, dec=0, new*=0, best_state=0.
- pm inputs are only sampled in CALC; their value in other states is don't-care.

Decomposition:
- Package viterbi_pkg holds: MW default, INF constant, the state encodings S00..S11, the expected-symbol function (ns, x) -> {c0,c1}, and the FSM state enum.
- One natural sub-module, acs_butterfly_cell: bm add, saturation and select for one next-state, instantiated 4 times.
- Normalization, best-state search and the FSM live in the top level.

Test Plan:
- After reset, pm = 0,15,15,15; sym=00; dec_ready=1 -> pm_we two cycles after accept; new = 0,15,2,15; dec=0000; best_state=0.
- Same pm; sym=11 -> new = 2,15,0,15; dec=0000; best_state=2.
- pm = 9,10,12,15; sym=01, NORM_EN=1 -> raw new00=min(10,11)=10 (dec0=0); after subtracting min, the minimum metric is 0 and INF values stay 15. Bench compares against a reference model.
- Tie check: pm00=pm01=3, sym such that both bm are equal -> dec[0]=0.
- Backpressure: hold dec_ready=0 for 5 cycles in OUT -> dec_valid=1 and new*/dec stable, no pm_we, sym_ready=0. Release -> single pm_we pulse, back to IDLE.
- Reset mid-op: assert rst_n=0 in CALC -> next cycle IDLE, dec_valid=0, pm_we never pulses; a sym_valid pulse during OUT is ignored.
